// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, XY direction codes, arbiter FSM states
// and the XY routing decision used by the router input stage.
package noc_pkg;

  localparam int FLIT_W = 8;

  // Header flit layout: [7:6] dest X, [5:4] dest Y, [3:0] payload length.
  localparam int HDR_DX_MSB  = 7;
  localparam int HDR_DX_LSB  = 6;
  localparam int HDR_DY_MSB  = 5;
  localparam int HDR_DY_LSB  = 4;
  localparam int HDR_LEN_MSB = 3;
  localparam int HDR_LEN_LSB = 0;

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_WEST  = 3'd2;
  localparam logic [2:0] DIR_NORTH = 3'd3;
  localparam logic [2:0] DIR_SOUTH = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] xy_route(input logic [FLIT_W-1:0] hdr,
                                          input logic [1:0]        x_here,
                                          input logic [1:0]        y_here);
    logic [1:0] dx;
    logic [1:0] dy;
    dx = hdr[HDR_DX_MSB:HDR_DX_LSB];
    dy = hdr[HDR_DY_MSB:HDR_DY_LSB];
    if (dx > x_here)      return DIR_EAST;
    else if (dx < x_here) return DIR_WEST;
    else if (dy > y_here) return DIR_NORTH;
    else if (dy < y_here) return DIR_SOUTH;
    else                  return DIR_LOCAL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: picks the first asserted request at or above
// ptr_i, wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          valid_o
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    logic [IW:0] pos;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    pos         = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!valid_o && req_i[pos[IW-1:0]]) begin
        valid_o              = 1'b1;
        grant_o[pos[IW-1:0]] = 1'b1;
        grant_idx_o          = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/flit_route_arbiter.sv
// Router input stage: round-robin picks a non-empty input FIFO, reads its
// header, computes the XY output direction and streams the whole packet to
// the crossbar.
//
// Output handshake: a flit transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data/out_dir/out_last
// hold steady until that transfer; valid is never withdrawn.
//
// FIFO side: in_read high in cycle t pops the FIFO; its data_out slice is
// valid during t+1 and is captured into the out register at the end of t+1.
// Only one read is ever outstanding (pending_q), giving 1 flit per 2 cycles.
module flit_route_arbiter
  import noc_pkg::*;
#(
  parameter int         N_IN    = 4,
  parameter logic [1:0] X_COORD = 2'd0,
  parameter logic [1:0] Y_COORD = 2'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_empty,
  input  logic [FLIT_W*N_IN-1:0]   in_data,
  output logic [N_IN-1:0]          in_read,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_dir,
  output logic                     out_last,
  output logic                     busy,
  output state_t                   dbg_state_o
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic                pending_q, pending_d;
  logic [3:0]          remaining_q, remaining_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [2:0]          out_dir_q, out_dir_d;
  logic                out_last_q, out_last_d;

  logic [N_IN-1:0]     arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic                rd_en;
  logic [IW-1:0]       rd_idx;
  logic                out_free;
  logic [FLIT_W-1:0]   cap_flit;
  logic [3:0]          cap_len;

  rr_arbiter #(.N(N_IN), .IW(IW)) u_rr (
    .req_i       (~in_empty),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  // The out register can take a new flit if empty or being drained now.
  assign out_free = !out_valid_q || out_ready;
  assign cap_flit = in_data[sel_q*FLIT_W +: FLIT_W];
  assign cap_len  = cap_flit[HDR_LEN_MSB:HDR_LEN_LSB];

  // Next-state, read issue and out-register update for the packet FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_dir_d   = out_dir_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    pending_d   = pending_q;
    rd_en       = 1'b0;
    rd_idx      = sel_q;
    case (state_q)
      IDLE: begin
        if (arb_valid && !pending_q && out_free) begin
          rd_en   = 1'b1;
          rd_idx  = arb_idx;
          sel_d   = arb_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        if (pending_q) begin
          pending_d   = 1'b0;
          out_data_d  = cap_flit;
          out_valid_d = 1'b1;
          out_dir_d   = xy_route(cap_flit, X_COORD, Y_COORD);
          remaining_d = cap_len;
          out_last_d  = (cap_len == 4'd0);
          state_d     = (cap_len == 4'd0) ? DRAIN : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pending_q) begin
          pending_d   = 1'b0;
          out_data_d  = cap_flit;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == 4'd1);
          if (remaining_q != 4'd0) remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) state_d = DRAIN;
        end else if (out_free && !in_empty[sel_q]) begin
          rd_en = 1'b1;
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          rr_ptr_d = (sel_q == IW'(N_IN-1)) ? '0 : sel_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) pending_d = 1'b1;
  end

  // Decode the read strobe; reset forces it low without waiting for a clock.
  always_comb begin
    in_read = '0;
    if (rd_en && rst) in_read[rd_idx] = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      pending_q   <= 1'b0;
      remaining_q <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_dir_q   <= DIR_LOCAL;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_dir_q   <= out_dir_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_dir     = out_dir_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
